// File: rtl/bist_pkg.sv
// ----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the half-adder BIST controller (ha_bist) and its
// pattern generator (lfsr_gen).
//   state_t  : controller FSM states
//   LFSR_TAPS: Fibonacci feedback mask for x^8+x^6+x^5+x^4+1
//   MISR_TAPS: MISR feedback mask (bits MSB, 5, 4, 3)
//   EXH_AB   : exhaustive stimulus, packed as {a,b}
//   EXH_SC   : golden half-adder response, packed as {s,c}
// ----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXH  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] MISR_TAPS = 8'hB8;

    localparam logic [1:0] EXH_AB [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    localparam logic [1:0] EXH_SC [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

endpackage

// File: rtl/lfsr_gen.sv
// ----------------------------------------------------------------------------
// lfsr_gen
// Fibonacci LFSR test-pattern source. Shifts left; the new bit0 is the parity
// of the tapped bits.
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset (register returns to SEED)
//   load    in   load SEED
//   advance in   step the register once
//   nxt_lo  out  low two bits of the value after the next step, so the
//                caller can register them in the same cycle the LFSR moves
// ----------------------------------------------------------------------------
module lfsr_gen
    import bist_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] TAPS = W'(LFSR_TAPS),
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [1:0] nxt_lo
);

    logic [W-1:0] q;
    logic [W-1:0] q_nxt;

    assign q_nxt  = {q[W-2:0], ^(q & TAPS)};
    assign nxt_lo = q_nxt[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (advance) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/ha_bist.sv
// ----------------------------------------------------------------------------
// ha_bist
// BIST controller for the half-adder cell: an LFSR drives the cell inputs, a
// MISR compacts the cell outputs, and the final signature is compared with
// GOLDEN. Define HA_BIST_EXHAUSTIVE_EN to add a 4-pattern exhaustive check
// after the pseudo-random phase.
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   start      in   one-cycle run request, ignored while busy
//   dut_s      in   sum from the cell under test
//   dut_c      in   carry from the cell under test
//   tpg_a      out  registered pattern bit to cell input a
//   tpg_b      out  registered pattern bit to cell input b
//   busy       out  run in progress (through the done cycle)
//   done       out  one-cycle result-valid pulse
//   pass       out  result of the last run
//   signature  out  final MISR value of the last run
//
// state | meaning
// IDLE  | waiting for start, pattern outputs held at 0
// RUN   | PATTERNS pseudo-random cycles, MISR compacting responses
// EXH   | 4 exhaustive patterns checked directly, MISR frozen
// DONE  | result registered, done pulse, back to IDLE
// ----------------------------------------------------------------------------
module ha_bist
    import bist_pkg::*;
#(
    parameter int                LFSR_W   = 8,
    parameter logic [LFSR_W-1:0] SEED     = 8'h01,
    parameter int                PATTERNS = 255,
    parameter int                MISR_W   = 8,
    parameter logic [MISR_W-1:0] GOLDEN   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dut_s,
    input  logic              dut_c,
    output logic              tpg_a,
    output logic              tpg_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    state_t              state;
    logic [LFSR_W-1:0]   cnt;
    logic [MISR_W-1:0]   misr;
    logic [MISR_W-1:0]   misr_next;
    logic                misr_fb;
    logic [1:0]          lfsr_nxt;
    logic                lfsr_load;
    logic                lfsr_adv;

    assign lfsr_load = (state == ST_IDLE) && start;
    assign lfsr_adv  = (state == ST_RUN);

    lfsr_gen #(
        .W    (LFSR_W),
        .TAPS (LFSR_W'(LFSR_TAPS)),
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .nxt_lo  (lfsr_nxt)
    );

    // Cell is combinational, so dut_s/dut_c belong to the tpg values of this cycle.
    always_comb begin
        misr_fb   = misr[MISR_W-1] ^ (^(misr[5:0] & MISR_TAPS[5:0])) ^ dut_s;
        misr_next = {misr[MISR_W-2:1], misr[0] ^ dut_c, misr_fb};
    end

`ifdef HA_BIST_EXHAUSTIVE_EN
    logic [1:0] exh_idx;
    logic       exh_err;
    logic       exh_bad;

    assign exh_bad = ({dut_s, dut_c} != EXH_SC[exh_idx]);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            misr      <= '0;
            tpg_a     <= 1'b0;
            tpg_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
`ifdef HA_BIST_EXHAUSTIVE_EN
            exh_idx   <= 2'd0;
            exh_err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        pass  <= 1'b0;
                        misr  <= '0;
                        cnt   <= LFSR_W'(PATTERNS - 1);
                        tpg_a <= SEED[0];
                        tpg_b <= SEED[1];
`ifdef HA_BIST_EXHAUSTIVE_EN
                        exh_err <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    misr <= misr_next;
                    if (cnt == '0) begin
`ifdef HA_BIST_EXHAUSTIVE_EN
                        state   <= ST_EXH;
                        exh_idx <= 2'd0;
                        tpg_a   <= EXH_AB[0][1];
                        tpg_b   <= EXH_AB[0][0];
`else
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        signature <= misr_next;
                        pass      <= (misr_next == GOLDEN);
                        tpg_a     <= 1'b0;
                        tpg_b     <= 1'b0;
`endif
                    end else begin
                        cnt   <= cnt - 1'b1;
                        tpg_a <= lfsr_nxt[0];
                        tpg_b <= lfsr_nxt[1];
                    end
                end
                ST_EXH: begin
`ifdef HA_BIST_EXHAUSTIVE_EN
                    if (exh_bad) begin
                        exh_err <= 1'b1;
                    end
                    if (exh_idx == 2'd3) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        signature <= misr;
                        // Include this cycle's comparison; exh_err has not caught it yet.
                        pass      <= (misr == GOLDEN) && !exh_err && !exh_bad;
                        tpg_a     <= 1'b0;
                        tpg_b     <= 1'b0;
                    end else begin
                        exh_idx <= exh_idx + 2'd1;
                        tpg_a   <= EXH_AB[exh_idx + 2'd1][1];
                        tpg_b   <= EXH_AB[exh_idx + 2'd1][0];
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ha_bist.sv
module tb_ha_bist;

`ifdef HA_BIST_EXHAUSTIVE_EN
    localparam int EXH = 4;
`else
    localparam int EXH = 0;
`endif
    localparam int         NPAT0 = 255;
    localparam int         NPAT1 = 1;
    localparam logic [7:0] GOLD0 = 8'h00;
    localparam logic [7:0] GOLD1 = 8'h01;
    localparam logic [7:0] SEED  = 8'h01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic f_or [2] = '{1'b0, 1'b0};
    logic f_c  [2] = '{1'b0, 1'b0};

    logic a0, b0, s0, c0, busy0, done0, pass0;
    logic a1, b1, s1, c1, busy1, done1, pass1;
    logic [7:0] sig0, sig1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    // Half-adder cells with optional injected faults.
    assign s0 = f_or[0] ? (a0 | b0) : (a0 ^ b0);
    assign c0 = f_c[0]  ? 1'b0      : (a0 & b0);
    assign s1 = f_or[1] ? (a1 | b1) : (a1 ^ b1);
    assign c1 = f_c[1]  ? 1'b0      : (a1 & b1);

    ha_bist #(.PATTERNS(NPAT0), .GOLDEN(GOLD0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_s(s0), .dut_c(c0),
        .tpg_a(a0), .tpg_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .signature(sig0)
    );

    ha_bist #(.PATTERNS(NPAT1), .GOLDEN(GOLD1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_s(s1), .dut_c(c1),
        .tpg_a(a1), .tpg_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1)
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] m, input logic s, input logic c);
        logic [7:0] r;
        r    = m << 1;
        r[0] = m[7] ^ m[5] ^ m[4] ^ m[3] ^ s;
        r[1] = m[0] ^ c;
        return r;
    endfunction

    // Whole-run signature from the pattern sequence.
    function automatic logic [7:0] model_sig(input int np, input logic for_f, input logic c_f);
        logic [7:0] l, m;
        logic a, b, s, c;
        l = SEED;
        m = 8'h00;
        for (int k = 0; k < np; k++) begin
            a = l[0];
            b = l[1];
            s = for_f ? (a | b) : (a ^ b);
            c = c_f ? 1'b0 : (a & b);
            m = misr_step(m, s, c);
            l = lfsr_step(l);
        end
        return m;
    endfunction

    // Cycle model: jm counts cycles since the accepted start
    // (1..np RUN, then EXH cycles, then the done cycle).
    int         jm    [2] = '{0, 0};
    logic [7:0] acc   [2] = '{8'h00, 8'h00};
    logic [7:0] lf    [2] = '{8'h00, 8'h00};
    logic       err   [2] = '{1'b0, 1'b0};
    logic       e_a   [2] = '{1'b0, 1'b0};
    logic       e_b   [2] = '{1'b0, 1'b0};
    logic       e_busy[2] = '{1'b0, 1'b0};
    logic       e_done[2] = '{1'b0, 1'b0};
    logic       e_pass[2] = '{1'b0, 1'b0};
    logic [7:0] e_sig [2] = '{8'h00, 8'h00};

    task automatic model_step(input int i, input logic st);
        int np;
        int idx;
        logic [7:0] gold;
        logic a, b, s, c;
        np   = (i == 0) ? NPAT0 : NPAT1;
        gold = (i == 0) ? GOLD0 : GOLD1;
        if (!rst_n) begin
            jm[i] = 0; acc[i] = 8'h00; err[i] = 1'b0;
            e_a[i] = 1'b0; e_b[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
            e_pass[i] = 1'b0; e_sig[i] = 8'h00;
        end else if (jm[i] == 0) begin
            e_done[i] = 1'b0;
            if (st) begin
                jm[i] = 1; e_busy[i] = 1'b1; e_pass[i] = 1'b0;
                acc[i] = 8'h00; err[i] = 1'b0; lf[i] = SEED;
                e_a[i] = SEED[0]; e_b[i] = SEED[1];
            end
        end else begin
            a = e_a[i];
            b = e_b[i];
            s = f_or[i] ? (a | b) : (a ^ b);
            c = f_c[i] ? 1'b0 : (a & b);
            if (jm[i] <= np) begin
                acc[i] = misr_step(acc[i], s, c);
                lf[i]  = lfsr_step(lf[i]);
            end else if (jm[i] <= np + EXH) begin
                if (s != (a ^ b) || c != (a & b)) err[i] = 1'b1;
            end
            jm[i]++;
            if (jm[i] <= np) begin
                e_a[i] = lf[i][0];
                e_b[i] = lf[i][1];
            end else if (jm[i] <= np + EXH) begin
                idx    = jm[i] - np - 1;
                e_a[i] = idx[1];
                e_b[i] = idx[0];
            end else if (jm[i] == np + EXH + 1) begin
                e_a[i] = 1'b0; e_b[i] = 1'b0; e_done[i] = 1'b1;
                e_sig[i]  = acc[i];
                e_pass[i] = (acc[i] == gold) && !err[i];
            end else begin
                jm[i] = 0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, start0);
        model_step(1, start1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every DUT output against the model.
    task automatic tick();
        @(negedge clk);
        if (cmp_en) begin
            chk("cyc_dut0 {a,b,busy,done,pass,sig}",
                {a0, b0, busy0, done0, pass0, sig0},
                {e_a[0], e_b[0], e_busy[0], e_done[0], e_pass[0], e_sig[0]});
            chk("cyc_dut1 {a,b,busy,done,pass,sig}",
                {a1, b1, busy1, done1, pass1, sig1},
                {e_a[1], e_b[1], e_busy[1], e_done[1], e_pass[1], e_sig[1]});
        end
    endtask

    // Start dut0 and wait (bounded) for done; lat counts cycles after start.
    task automatic run0(output logic [7:0] sig, output logic ps, output int lat);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        lat = 1;
        while (!done0 && lat < 400) begin
            tick();
            lat++;
        end
        chk("run0_done_seen", {31'd0, done0}, 32'd1);
        sig = sig0;
        ps  = pass0;
    endtask

    logic [7:0] good_sig, stuck_sig, l, r_sig;
    logic       r_pass;
    int         lat, ndone, first_done, period;

    initial begin
        // Model pins (hand-computed).
        chk("pin_lfsr_step_01", {24'd0, lfsr_step(8'h01)}, 32'h02);
        l = SEED;
        period = 0;
        do begin
            l = lfsr_step(l);
            period++;
        end while (l != SEED && period < 300);
        chk("pin_lfsr_period", period, 255);
        chk("pin_sig_p1", {24'd0, model_sig(1, 1'b0, 1'b0)}, 32'h01);
        chk("pin_sig_p2", {24'd0, model_sig(2, 1'b0, 1'b0)}, 32'h03);
        good_sig  = model_sig(NPAT0, 1'b0, 1'b0);
        stuck_sig = model_sig(NPAT0, 1'b0, 1'b1);

        tick();
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_tpg0", {30'd0, a0, b0}, 32'd0);
        chk("rst_sig0", {24'd0, sig0}, 32'd0);
        chk("rst_pass0", {31'd0, pass0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // PATTERNS = 1: one RUN cycle with (a,b)=(1,0), done at T+2.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("p1_busy_T1", {31'd0, busy1}, 32'd1);
        chk("p1_ab_T1", {30'd0, a1, b1}, 32'b10);
        for (int k = 0; k < EXH; k++) tick();
        tick();
        chk("p1_done_T2", {31'd0, done1}, 32'd1);
        chk("p1_sig", {24'd0, sig1}, 32'h01);
        chk("p1_pass", {31'd0, pass1}, 32'd1);
        tick();
        chk("p1_busy_drop", {31'd0, busy1}, 32'd0);
        chk("p1_done_drop", {31'd0, done1}, 32'd0);

        // Golden run with restart attempts at RUN cycle 5 and in the DONE cycle.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        ndone = 0;
        first_done = 0;
        for (int c = 1; c <= 300 + EXH; c++) begin
            if (done0) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = c;
                    r_sig  = sig0;
                    r_pass = pass0;
                end
            end
            start0 = (c == 5) || done0;
            tick();
        end
        start0 = 1'b0;
        chk("golden_done_count", ndone, 1);
        chk("golden_done_cycle", first_done, 256 + EXH);
        chk("golden_sig", {24'd0, r_sig}, {24'd0, good_sig});
        chk("golden_pass", {31'd0, r_pass}, {31'd0, good_sig == GOLD0});
        tick();

        // Stuck-at-0 carry.
        f_c[0] = 1'b1;
        run0(r_sig, r_pass, lat);
        chk("stuck_lat", lat, 256 + EXH);
        chk("stuck_sig", {24'd0, r_sig}, {24'd0, stuck_sig});
        chk("stuck_sig_differs", {31'd0, r_sig != good_sig}, 32'd1);
        chk("stuck_pass", {31'd0, r_pass}, {31'd0, stuck_sig == GOLD0});
        f_c[0] = 1'b0;
        tick();
        tick();

        // Reset at RUN cycle 10.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_tpg", {30'd0, a0, b0}, 32'd0);
        chk("midrst_sig", {24'd0, sig0}, 32'd0);
        chk("midrst_pass", {31'd0, pass0}, 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef HA_BIST_EXHAUSTIVE_EN
        // OR fault: signature still matches, exhaustive pattern 11 catches it.
        f_or[1] = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        tick();
        chk("exh_or_done", {31'd0, done1}, 32'd1);
        chk("exh_or_sig", {24'd0, sig1}, 32'h01);
        chk("exh_or_pass", {31'd0, pass1}, 32'd0);
        f_or[1] = 1'b0;
        tick();
        tick();
`endif

        // Randomized traffic, faults and resets against the cycle model.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 2; i++) begin
                f_or[i] = ($urandom_range(0, 3) == 0);
                f_c[i]  = ($urandom_range(0, 3) == 0);
            end
            for (int c = 0; c < 400; c++) begin
                start0 = ($urandom_range(0, 15) == 0);
                start1 = ($urandom_range(0, 3) == 0);
                rst_n  = ($urandom_range(0, 499) != 0);
                tick();
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n  = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
